video_timing_ctrl: RTL and testbench
====================================

# video_timing_ctrl

Register-programmable controller that configures the video timing generator. Holds a shadow copy of all horizontal and vertical timing parameters plus the pal/scandouble mode bits, written by the CPU over a simple single-cycle register bus. It copies the shadow into the active set only at a frame boundary, so the display never sees a torn frame. It also provides preset loading, commit validation, a frame counter and a frame-applied interrupt.

## Interface

Parameters:
- none; all widths fixed (timing fields 10 bits, bus data 16 bits, address 4 bits)

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset; synchronous, active-low.
- ce_pix  in  1  pixel enable from the timing generator.
- frame_end  in  1  high on the last pixel of a frame (hc==h_total and vc==v_total); qualified by ce_pix.
- wr  in  1  register write strobe, one cycle.
- rd  in  1  register read strobe, one cycle.
- addr  in  4  register address.
- wdata  in  16  write data; bits above the field width are ignored.
- rdata  out  16  read data, registered; valid when ack is high.
- ack  out  1  one-cycle acknowledge, exactly 1 cycle after wr or rd.
- h_total, h_blank, hs_start, hs_end  out  10 each  active horizontal timing.
- v_total, vb_start, vs_start, vs_end  out  10 each  active vertical timing.
- pal, scandouble  out  1 each  active mode bits.
- irq  out  1  level interrupt = irq_flag AND irq_en.

## Operation

Register map (read/write unless noted):
- 0 CTRL
  - bit0 pal (shadow)
  - bit1 scandouble (shadow)
  - bit2 PRESET: write-1 action, reads 0
  - bit3 irq_en
  - bit4 COMMIT: write-1 action, reads 0
- 1–8: shadow h_total, h_blank, hs_start, hs_end, v_total, vb_start, vs_start, vs_end.
- 9 STATUS
  - bit0 pending (RO)
  - bit1 irq_flag (W1C)
  - bit2 err (W1C)
- 10 FRAME_CNT (RO): 16-bit count of frame_end events; wraps 0xFFFF→0.
- 11–15: read 0; writes ignored, still acked.

PRESET:
- Loads the shadow from the shadow pal/scandouble bits written in the same CTRL write.
- Horizontal, all modes: h_total 637, h_blank 529, hs 544/590.
- Vertical, NTSC: v_total 261/523, vb 240/480, vs 245/248 or 490/496 (values given as non-scandoubled / scandoubled).
- Vertical, PAL: v_total 311/623, vb 300/601, vs 304/308 or 609/617 (non-scandoubled / scandoubled).
- If PRESET and COMMIT are set in the same write, the commit uses the preset values.

COMMIT validation, checked on the shadow at the write cycle:
- h_blank ≤ h_total
- hs_start < hs_end ≤ h_total
- vb_start ≤ v_total
- vs_start < vs_end ≤ v_total
- On failure: err=1, nothing becomes pending.

State machine:
- IDLE → PEND on a valid COMMIT (pending=1).
- PEND → APPLY on ce_pix & frame_end.
- APPLY lasts 1 cycle: copy shadow → active, pending=0, irq_flag=1, return to IDLE.
- While in PEND:
  - Shadow writes are accepted; the last value written before the transition into APPLY is what gets applied.
  - A further COMMIT re-validates. Valid: stays PEND. Invalid: sets err, stays PEND with the new shadow, which may then apply invalid values. Software must check err.

Reset values:
- Active outputs and shadow = NTSC, non-scandouble preset.
- pal=0, scandouble=0.
- irq_en=0, irq_flag=0, err=0, pending=0, FRAME_CNT=0.
- rdata=0, ack=0.
- State = IDLE.

## Timing

- Bus: wr or rd in cycle N → ack and rdata in cycle N+1. Reads return state as of cycle N.
- wr and rd asserted together: the write is performed, rdata=0.
- Active outputs change only in the cycle after the APPLY cycle, so they are stable for the pixel following frame_end.
- Latency from the qualified frame_end cycle to new active outputs: 2 clk.
- COMMIT written in the same cycle as a qualified frame_end: does not apply at that frame, applies at the next one.
- frame_end seen while not in PEND: only FRAME_CNT increments (in the same cycle for all states).
- W1C of irq_flag in the same cycle irq_flag is set by APPLY: set wins. Same rule for err when a commit fails in the same cycle it is cleared.
- frame_end is ignored when ce_pix=0.
- reset_n low mid-PEND: the pending commit is discarded; outputs revert to reset values in the next cycle.

## Test plan

- Reset: hold reset_n=0 for 3 clk → h_total=637, v_total=261, vs_start=245, pal=0, irq=0, STATUS reads 0.
- Preset and commit: write CTRL=0x17 (pal, sd, PRESET, COMMIT) → pending=1, active unchanged; after qualified frame_end, 2 clk later v_total=623, vs_start=609, vs_end=617, vb_start=601, pending=0, irq_flag=1.
- Invalid commit: write hs_start=600, hs_end=590, then COMMIT → err=1, pending=0, active h unchanged; W1C STATUS=0x4 → err=0.
- Late shadow write: commit valid v_total=300, then write v_total=280 before frame_end → applied v_total=280.
- Boundary collisions:
  - COMMIT written in the same cycle as frame_end → not applied until the second frame_end.
  - irq W1C in the APPLY cycle → irq_flag stays 1.
  - irq_en=1 → irq high.
- Frame counter: 65537 qualified frame_end pulses → FRAME_CNT=1; frame_end with ce_pix=0 → no increment.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Purpose: CPU-programmable shadow/active video timing registers with frame-boundary commit.
// Latency: bus ack/rdata 1 clk after wr/rd; qualified frame_end to new active outputs 2 clk.
// Backpressure: none; every wr/rd is accepted and acked the next cycle.
module video_timing_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        frame_end,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic [9:0]  h_total,
  output logic [9:0]  h_blank,
  output logic [9:0]  hs_start,
  output logic [9:0]  hs_end,
  output logic [9:0]  v_total,
  output logic [9:0]  vb_start,
  output logic [9:0]  vs_start,
  output logic [9:0]  vs_end,
  output logic        pal,
  output logic        scandouble,
  output logic        irq
);

  typedef struct packed {
    logic [9:0] h_total;
    logic [9:0] h_blank;
    logic [9:0] hs_start;
    logic [9:0] hs_end;
    logic [9:0] v_total;
    logic [9:0] vb_start;
    logic [9:0] vs_start;
    logic [9:0] vs_end;
    logic       pal;
    logic       scandouble;
  } timing_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Standard timing for each pal/scandouble combination; horizontal is mode-independent.
  function automatic timing_t preset_fn(input logic p, input logic sd);
    timing_t t;
    t.h_total    = 10'd637;
    t.h_blank    = 10'd529;
    t.hs_start   = 10'd544;
    t.hs_end     = 10'd590;
    t.pal        = p;
    t.scandouble = sd;
    case ({p, sd})
      2'b00:   begin t.v_total = 10'd261; t.vb_start = 10'd240; t.vs_start = 10'd245; t.vs_end = 10'd248; end
      2'b01:   begin t.v_total = 10'd523; t.vb_start = 10'd480; t.vs_start = 10'd490; t.vs_end = 10'd496; end
      2'b10:   begin t.v_total = 10'd311; t.vb_start = 10'd300; t.vs_start = 10'd304; t.vs_end = 10'd308; end
      default: begin t.v_total = 10'd623; t.vb_start = 10'd601; t.vs_start = 10'd609; t.vs_end = 10'd617; end
    endcase
    return t;
  endfunction

  state_t      state_q, state_d;
  timing_t     shadow_q, shadow_d;
  timing_t     active_q;
  logic        irq_en_q;
  logic        irq_flag_q;
  logic        err_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] rd_mux;
  logic        commit;
  logic        commit_ok;
  logic        frame_tick;
  logic        pending;
  logic        status_wr;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[15:10];
  assign frame_tick      = ce_pix & frame_end;
  assign pending         = (state_q == PEND);
  assign status_wr       = wr && (addr == 4'd9);
  assign commit          = wr && (addr == 4'd0) && wdata[4];

  // Shadow as it will look after this cycle's write; commit validates this view so PRESET+COMMIT uses preset values.
  always_comb begin
    shadow_d = shadow_q;
    if (wr) begin
      case (addr)
        4'd0: begin
          shadow_d.pal        = wdata[0];
          shadow_d.scandouble = wdata[1];
          if (wdata[2]) shadow_d = preset_fn(wdata[0], wdata[1]);
        end
        4'd1:    shadow_d.h_total  = wdata[9:0];
        4'd2:    shadow_d.h_blank  = wdata[9:0];
        4'd3:    shadow_d.hs_start = wdata[9:0];
        4'd4:    shadow_d.hs_end   = wdata[9:0];
        4'd5:    shadow_d.v_total  = wdata[9:0];
        4'd6:    shadow_d.vb_start = wdata[9:0];
        4'd7:    shadow_d.vs_start = wdata[9:0];
        4'd8:    shadow_d.vs_end   = wdata[9:0];
        default: shadow_d = shadow_q;
      endcase
    end
    commit_ok = (shadow_d.h_blank  <= shadow_d.h_total) &&
                (shadow_d.hs_start <  shadow_d.hs_end)  &&
                (shadow_d.hs_end   <= shadow_d.h_total) &&
                (shadow_d.vb_start <= shadow_d.v_total) &&
                (shadow_d.vs_start <  shadow_d.vs_end)  &&
                (shadow_d.vs_end   <= shadow_d.v_total);
  end

  // Next state: a commit in the frame_end cycle wins, so that frame is skipped and the next one applies.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit && commit_ok) state_d = PEND;
      PEND:    if (!commit && frame_tick) state_d = APPLY;
      APPLY:   state_d = (commit && commit_ok) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux reflects register state as of the request cycle.
  always_comb begin
    rd_mux = 16'd0;
    case (addr)
      4'd0:    rd_mux = {11'd0, 1'b0, irq_en_q, 1'b0, shadow_q.scandouble, shadow_q.pal};
      4'd1:    rd_mux = {6'd0, shadow_q.h_total};
      4'd2:    rd_mux = {6'd0, shadow_q.h_blank};
      4'd3:    rd_mux = {6'd0, shadow_q.hs_start};
      4'd4:    rd_mux = {6'd0, shadow_q.hs_end};
      4'd5:    rd_mux = {6'd0, shadow_q.v_total};
      4'd6:    rd_mux = {6'd0, shadow_q.vb_start};
      4'd7:    rd_mux = {6'd0, shadow_q.vs_start};
      4'd8:    rd_mux = {6'd0, shadow_q.vs_end};
      4'd9:    rd_mux = {13'd0, err_q, irq_flag_q, pending};
      4'd10:   rd_mux = frame_cnt_q;
      default: rd_mux = 16'd0;
    endcase
  end

  // Commit state register; reset discards any pending commit.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Shadow/active timing sets, control/status bits, frame counter and bus response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q    <= preset_fn(1'b0, 1'b0);
      active_q    <= preset_fn(1'b0, 1'b0);
      irq_en_q    <= 1'b0;
      irq_flag_q  <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      rdata       <= 16'd0;
      ack         <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (state_q == APPLY) active_q <= shadow_q;
      if (wr && (addr == 4'd0)) irq_en_q <= wdata[3];
      if (state_q == APPLY)            irq_flag_q <= 1'b1;
      else if (status_wr && wdata[1])  irq_flag_q <= 1'b0;
      if (commit && !commit_ok)        err_q <= 1'b1;
      else if (status_wr && wdata[2])  err_q <= 1'b0;
      if (frame_tick) frame_cnt_q <= frame_cnt_q + 16'd1;
      ack   <= wr | rd;
      rdata <= (rd && !wr) ? rd_mux : 16'd0;
    end
  end

  assign h_total    = active_q.h_total;
  assign h_blank    = active_q.h_blank;
  assign hs_start   = active_q.hs_start;
  assign hs_end     = active_q.hs_end;
  assign v_total    = active_q.v_total;
  assign vb_start   = active_q.vb_start;
  assign vs_start   = active_q.vs_start;
  assign vs_end     = active_q.vs_end;
  assign pal        = active_q.pal;
  assign scandouble = active_q.scandouble;
  assign irq        = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Purpose: directed self-checking bench for video_timing_ctrl with a read scoreboard.
// Latency: expects ack/rdata one clk after each strobe, active update 2 clk after frame_end.
// Backpressure: none exercised; the DUT always accepts.
module tb_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b1;
  logic        frame_end = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata;
  logic        ack;
  logic [9:0]  h_total, h_blank, hs_start, hs_end;
  logic [9:0]  v_total, vb_start, vs_start, vs_end;
  logic        pal, scandouble, irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  video_timing_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .frame_end(frame_end),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
    .h_total(h_total), .h_blank(h_blank), .hs_start(hs_start), .hs_end(hs_end),
    .v_total(v_total), .vb_start(vb_start), .vs_start(vs_start), .vs_end(vs_end),
    .pal(pal), .scandouble(scandouble), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge following a strobe: pops the oldest expectation.
  task automatic collect();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_ack"}, {15'd0, ack}, 16'd1);
      chk(x.tag, rdata, x.exp);
    end
  endtask

  // All bus tasks start and end on a negedge.
  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
    chk("wr_ack", {15'd0, ack}, 16'd1);
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [15:0] e, input string tag);
    exp_t x;
    x.tag = tag; x.exp = e;
    sb.push_back(x);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    collect();
  endtask

  task automatic fe_pulse(input logic ce);
    ce_pix = ce; frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0; ce_pix = 1'b1;
  endtask

  initial begin
    exp_t x;
    // Reset held for 3 clocks
    repeat (3) @(negedge clk);
    chk("rst_h_total", {6'd0, h_total}, 16'd637);
    chk("rst_v_total", {6'd0, v_total}, 16'd261);
    chk("rst_vs_start", {6'd0, vs_start}, 16'd245);
    chk("rst_pal", {15'd0, pal}, 16'd0);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_ack", {15'd0, ack}, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    reset_n = 1'b1;
    rd_reg(4'd9, 16'h0000, "rst_status");
    rd_reg(4'd10, 16'h0000, "rst_frame_cnt");
    rd_reg(4'd1, 16'd637, "rst_shadow_h_total");

    // PRESET + COMMIT to PAL scandouble
    wr_reg(4'd0, 16'h0017);
    rd_reg(4'd9, 16'h0001, "pc_pending");
    chk("pc_active_unchanged", {6'd0, v_total}, 16'd261);
    rd_reg(4'd5, 16'd623, "pc_shadow_v_total");
    rd_reg(4'd0, 16'h0003, "pc_ctrl");
    fe_pulse(1'b1);
    chk("pc_apply_cycle_stable", {6'd0, v_total}, 16'd261);
    @(negedge clk);
    chk("pc_v_total", {6'd0, v_total}, 16'd623);
    chk("pc_vs_start", {6'd0, vs_start}, 16'd609);
    chk("pc_vs_end", {6'd0, vs_end}, 16'd617);
    chk("pc_vb_start", {6'd0, vb_start}, 16'd601);
    chk("pc_modes", {14'd0, pal, scandouble}, 16'd3);
    chk("pc_h_total", {6'd0, h_total}, 16'd637);
    rd_reg(4'd9, 16'h0002, "pc_status_irq");
    chk("pc_irq_masked", {15'd0, irq}, 16'd0);

    // Invalid commit: hs_start >= hs_end
    wr_reg(4'd9, 16'h0002);
    wr_reg(4'd3, 16'd600);
    wr_reg(4'd4, 16'd590);
    wr_reg(4'd0, 16'h0010);
    rd_reg(4'd9, 16'h0004, "inv_err");
    fe_pulse(1'b1);
    @(negedge clk);
    chk("inv_hs_start", {6'd0, hs_start}, 16'd544);
    chk("inv_hs_end", {6'd0, hs_end}, 16'd590);
    wr_reg(4'd9, 16'h0004);
    rd_reg(4'd9, 16'h0000, "inv_err_clr");

    // Late shadow write while pending
    wr_reg(4'd0, 16'h0004);
    wr_reg(4'd5, 16'd300);
    wr_reg(4'd0, 16'h0010);
    rd_reg(4'd9, 16'h0001, "late_pending");
    wr_reg(4'd5, 16'd280);
    fe_pulse(1'b1);
    @(negedge clk);
    chk("late_v_total", {6'd0, v_total}, 16'd280);
    chk("late_vb_start", {6'd0, vb_start}, 16'd240);
    chk("late_pal", {15'd0, pal}, 16'd0);
    rd_reg(4'd9, 16'h0002, "late_status");

    // COMMIT in the same cycle as a qualified frame_end
    wr_reg(4'd9, 16'h0002);
    wr_reg(4'd5, 16'd270);
    wr = 1'b1; addr = 4'd0; wdata = 16'h0010; frame_end = 1'b1; ce_pix = 1'b1;
    @(negedge clk);
    wr = 1'b0; frame_end = 1'b0;
    chk("col_ack", {15'd0, ack}, 16'd1);
    @(negedge clk);
    chk("col_not_applied", {6'd0, v_total}, 16'd280);
    rd_reg(4'd9, 16'h0001, "col_pending");
    fe_pulse(1'b1);
    @(negedge clk);
    chk("col_applied", {6'd0, v_total}, 16'd270);

    // irq_flag W1C landing in the APPLY cycle
    wr_reg(4'd9, 16'h0002);
    rd_reg(4'd9, 16'h0000, "w1c_clear");
    wr_reg(4'd0, 16'h0018);
    rd_reg(4'd9, 16'h0001, "w1c_pending");
    chk("w1c_irq_low", {15'd0, irq}, 16'd0);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0; wr = 1'b1; addr = 4'd9; wdata = 16'h0002;
    @(negedge clk);
    wr = 1'b0;
    chk("w1c_irq_high", {15'd0, irq}, 16'd1);
    rd_reg(4'd9, 16'h0002, "w1c_set_wins");
    wr_reg(4'd9, 16'h0002);
    chk("w1c_irq_cleared", {15'd0, irq}, 16'd0);

    // Reset while a commit is pending
    wr_reg(4'd5, 16'd290);
    wr_reg(4'd0, 16'h0010);
    reset_n = 1'b0;
    @(negedge clk);
    chk("prst_v_total", {6'd0, v_total}, 16'd261);
    chk("prst_ack", {15'd0, ack}, 16'd0);
    reset_n = 1'b1;
    rd_reg(4'd5, 16'd261, "prst_shadow");
    rd_reg(4'd10, 16'h0000, "fc_zero");
    fe_pulse(1'b0);
    rd_reg(4'd10, 16'h0000, "fc_ce_low");
    fe_pulse(1'b1);
    @(negedge clk);
    chk("prst_discarded", {6'd0, v_total}, 16'd261);
    rd_reg(4'd9, 16'h0000, "prst_status");
    rd_reg(4'd10, 16'h0001, "fc_one");

    // Frame counter wrap: 65537 total qualified pulses
    ce_pix = 1'b1; frame_end = 1'b1;
    repeat (65536) @(negedge clk);
    frame_end = 1'b0;
    rd_reg(4'd10, 16'h0001, "fc_wrap");

    // Simultaneous wr+rd returns 0; RO and unmapped addresses
    x.tag = "wrrd_zero"; x.exp = 16'h0000;
    sb.push_back(x);
    wr = 1'b1; rd = 1'b1; addr = 4'd10; wdata = 16'h1234;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    collect();
    rd_reg(4'd10, 16'h0001, "fc_ro");
    wr_reg(4'd12, 16'hFFFF);
    rd_reg(4'd12, 16'h0000, "unmapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
